ladybird_inst_decoder: RTL and testbench

Pipelined RV32I instruction decoder: the receiving end of the instruction-word encodings the core builds with its constructor functions (ADDI, LB, SB, JAL, …). It accepts a raw 32-bit instruction plus PC on a valid/ready handshake and emits a registered, fully unpacked record. The record carries the format class, register indices, funct fields, a sign-extended immediate and an illegal flag. It sits between instruction fetch and execute, and a 2-entry skid buffer gives full throughput under backpressure.

---
 rtl/ladybird_inst_decoder.sv | 191 +++++++++++++++++++
 tb/tb_ladybird_inst_decoder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ladybird_inst_decoder.sv
// RV32I instruction decoder: combinational field extraction feeding a two-entry
// (main + skid) output buffer so decode runs at full rate under backpressure.
module ladybird_inst_decoder #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [2:0]      out_format,
    output logic [4:0]      out_opcode,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [XLEN-1:0] out_imm,
    output logic            out_illegal
);

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [4:0] OPC_LOAD     = 5'b00000;
    localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
    localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
    localparam logic [4:0] OPC_AUIPC    = 5'b00101;
    localparam logic [4:0] OPC_STORE    = 5'b01000;
    localparam logic [4:0] OPC_OP       = 5'b01100;
    localparam logic [4:0] OPC_LUI      = 5'b01101;
    localparam logic [4:0] OPC_BRANCH   = 5'b11000;
    localparam logic [4:0] OPC_JALR     = 5'b11001;
    localparam logic [4:0] OPC_JAL      = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [2:0]      format;
        logic [4:0]      opcode;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [XLEN-1:0] imm;
        logic            illegal;
    } rec_t;

    logic [4:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    fmt_e        fmt;
    logic        known;
    logic        bad_funct;
    logic [31:0] imm32;
    rec_t        dec;

    assign opc = in_inst[6:2];
    assign f3  = in_inst[14:12];
    assign f7  = in_inst[31:25];

    // Format class and opcode-specific funct legality.
    always_comb begin
        fmt       = FMT_I;
        known     = 1'b1;
        bad_funct = 1'b0;
        case (opc)
            OPC_LUI, OPC_AUIPC: fmt = FMT_U;
            OPC_JAL:            fmt = FMT_J;
            OPC_STORE: begin
                fmt       = FMT_S;
                bad_funct = (f3 >= 3'd3);
            end
            OPC_BRANCH: begin
                fmt       = FMT_B;
                bad_funct = (f3 == 3'd2) || (f3 == 3'd3);
            end
            OPC_OP: begin
                fmt = FMT_R;
                if (f7 == 7'h00)
                    bad_funct = 1'b0;
                else if (f7 == 7'h20)
                    bad_funct = !((f3 == 3'd0) || (f3 == 3'd5));
                else
                    bad_funct = 1'b1;
            end
            OPC_LOAD:
                bad_funct = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
            OPC_JALR:
                bad_funct = (f3 != 3'd0);
            OPC_OP_IMM: begin
                if (f3 == 3'd1)
                    bad_funct = (f7 != 7'h00);
                else if (f3 == 3'd5)
                    bad_funct = (f7 != 7'h00) && (f7 != 7'h20);
                else
                    bad_funct = 1'b0;
            end
            OPC_SYSTEM, OPC_MISC_MEM: bad_funct = 1'b0;
            default: known = 1'b0;
        endcase
    end

    always_comb begin
        imm32 = 32'd0;
        case (fmt)
            FMT_I: imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
            FMT_S: imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            FMT_B: imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                            in_inst[30:25], in_inst[11:8], 1'b0};
            FMT_U: imm32 = {in_inst[31:12], 12'd0};
            FMT_J: imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                            in_inst[20], in_inst[30:21], 1'b0};
            default: imm32 = 32'd0;
        endcase
    end

    always_comb begin
        dec         = '0;
        dec.pc      = in_pc;
        dec.format  = fmt;
        dec.opcode  = opc;
        dec.rd      = (fmt == FMT_S || fmt == FMT_B) ? 5'd0 : in_inst[11:7];
        dec.rs1     = (fmt == FMT_U || fmt == FMT_J) ? 5'd0 : in_inst[19:15];
        dec.rs2     = (fmt == FMT_R || fmt == FMT_S || fmt == FMT_B) ? in_inst[24:20] : 5'd0;
        dec.funct3  = (fmt == FMT_U || fmt == FMT_J) ? 3'd0 : f3;
        dec.funct7  = (fmt == FMT_R) ? f7 : 7'd0;
        dec.imm     = {{(XLEN-31){imm32[31]}}, imm32[30:0]};
        dec.illegal = (in_inst[1:0] != 2'b11) || !known || bad_funct;
    end

    rec_t main_reg;
    rec_t skid_reg;
    logic main_valid_reg;
    logic skid_valid_reg;

    assign in_ready  = !skid_valid_reg;
    assign out_valid = main_valid_reg;

    // Main refills whenever it is empty or draining; skid only catches the
    // item that arrives while main is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_reg       <= '0;
            skid_reg       <= '0;
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else if (flush) begin
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else if (!main_valid_reg || out_ready) begin
            if (skid_valid_reg) begin
                main_reg       <= skid_reg;
                main_valid_reg <= 1'b1;
                skid_valid_reg <= 1'b0;
            end else if (in_valid) begin
                main_reg       <= dec;
                main_valid_reg <= 1'b1;
            end else begin
                main_valid_reg <= 1'b0;
            end
        end else if (in_valid && !skid_valid_reg) begin
            skid_reg       <= dec;
            skid_valid_reg <= 1'b1;
        end
    end

    assign out_pc      = main_reg.pc;
    assign out_format  = main_reg.format;
    assign out_opcode  = main_reg.opcode;
    assign out_rd      = main_reg.rd;
    assign out_rs1     = main_reg.rs1;
    assign out_rs2     = main_reg.rs2;
    assign out_funct3  = main_reg.funct3;
    assign out_funct7  = main_reg.funct7;
    assign out_imm     = main_reg.imm;
    assign out_illegal = main_reg.illegal;

endmodule

// File: tb/tb_ladybird_inst_decoder.sv
// Bench for ladybird_inst_decoder: directed test-plan cases plus random traffic
// checked against an arithmetic decode model and a FIFO occupancy model.
module tb_ladybird_inst_decoder;

    typedef logic [97:0] vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [2:0]  out_format;
    logic [4:0]  out_opcode;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;
    logic [31:0] out_imm;
    logic        out_illegal;

    int total = 0;
    int bad = 0;
    vec_t q[$];
    logic [31:0] outlog[$];

    ladybird_inst_decoder #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_format(out_format), .out_opcode(out_opcode), .out_rd(out_rd),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_funct3(out_funct3),
        .out_funct7(out_funct7), .out_imm(out_imm), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    // Expected record from the ISA rules, built with plain integer arithmetic.
    function automatic vec_t model(input logic [31:0] inst, input logic [31:0] pc);
        int opc = int'(inst[6:2]);
        int f3 = int'(inst[14:12]);
        int f7 = int'(inst[31:25]);
        int fmt;
        int imm;
        int of3;
        int of7;
        bit known = 1'b1;
        bit ill;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        case (opc)
            'h0D, 'h05: fmt = 4;
            'h1B: fmt = 5;
            'h08: fmt = 2;
            'h18: fmt = 3;
            'h0C: fmt = 0;
            'h19, 'h00, 'h04, 'h1C, 'h03: fmt = 1;
            default: begin fmt = 1; known = 1'b0; end
        endcase
        ill = (inst[1:0] != 2'b11) || !known;
        if (opc == 'h00 && (f3 == 3 || f3 >= 6)) ill = 1'b1;
        if (opc == 'h08 && f3 >= 3) ill = 1'b1;
        if (opc == 'h18 && (f3 == 2 || f3 == 3)) ill = 1'b1;
        if (opc == 'h19 && f3 != 0) ill = 1'b1;
        if (opc == 'h0C && !(f7 == 0 || (f7 == 'h20 && (f3 == 0 || f3 == 5)))) ill = 1'b1;
        if (opc == 'h04 && f3 == 1 && f7 != 0) ill = 1'b1;
        if (opc == 'h04 && f3 == 5 && f7 != 0 && f7 != 'h20) ill = 1'b1;
        case (fmt)
            1: begin
                imm = int'(inst[31:20]);
                if (imm >= 2048) imm -= 4096;
            end
            2: begin
                imm = int'(inst[31:25]) * 32 + int'(inst[11:7]);
                if (imm >= 2048) imm -= 4096;
            end
            3: begin
                imm = int'(inst[7]) * 2048 + int'(inst[30:25]) * 32 + int'(inst[11:8]) * 2;
                if (inst[31]) imm -= 4096;
            end
            4: imm = int'(inst[31:12]) << 12;
            5: begin
                imm = int'(inst[19:12]) * 4096 + int'(inst[20]) * 2048 + int'(inst[30:21]) * 2;
                if (inst[31]) imm -= (1 << 20);
            end
            default: imm = 0;
        endcase
        rd  = (fmt == 2 || fmt == 3) ? 5'd0 : inst[11:7];
        rs1 = (fmt >= 4) ? 5'd0 : inst[19:15];
        rs2 = (fmt == 0 || fmt == 2 || fmt == 3) ? inst[24:20] : 5'd0;
        of3 = (fmt >= 4) ? 0 : f3;
        of7 = (fmt == 0) ? f7 : 0;
        return {pc, 3'(fmt), inst[6:2], rd, rs1, rs2, 3'(of3), 7'(of7), 32'(imm), ill};
    endfunction

    function automatic vec_t observed();
        return {out_pc, out_format, out_opcode, out_rd, out_rs1, out_rs2,
                out_funct3, out_funct7, out_imm, out_illegal};
    endfunction

    task automatic chk(input string tag, input vec_t obs, input vec_t exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs are already driven; compare the current outputs, update the
    // model for the coming edge, then advance one cycle to the next negedge.
    task automatic step(output bit fired);
        bit ofire;
        chk("out_valid", vec_t'(out_valid), vec_t'(q.size() != 0));
        chk("in_ready", vec_t'(in_ready), vec_t'(q.size() < 2));
        if (q.size() != 0) chk("record", observed(), q[0]);
        ofire = (q.size() != 0) && out_ready;
        fired = in_valid && (q.size() < 2) && !flush;
        if (ofire) begin
            $display("xfer pc=%h rec=%h", q[0][97:66], q[0]);
            outlog.push_back(q[0][97:66]);
            void'(q.pop_front());
        end
        if (flush) q.delete();
        else if (fired) q.push_back(model(in_inst, in_pc));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        bit f;
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4 && q.size() != 0; i++) step(f);
    endtask

    task automatic dec_check(input string tag, input logic [31:0] inst, input int fmt,
                             input int rd, input int rs1, input int rs2,
                             input logic [31:0] imm, input bit ill);
        bit f;
        drain();
        in_valid = 1'b1; in_inst = inst; in_pc = 32'h100; out_ready = 1'b1;
        step(f);
        in_valid = 1'b0;
        chk({tag, "_valid"}, vec_t'(out_valid), vec_t'(1));
        chk({tag, "_fmt"}, vec_t'(out_format), vec_t'(fmt));
        chk({tag, "_rd"}, vec_t'(out_rd), vec_t'(rd));
        chk({tag, "_rs1"}, vec_t'(out_rs1), vec_t'(rs1));
        chk({tag, "_rs2"}, vec_t'(out_rs2), vec_t'(rs2));
        chk({tag, "_imm"}, vec_t'(out_imm), vec_t'(imm));
        chk({tag, "_ill"}, vec_t'(out_illegal), vec_t'(ill));
        step(f);
    endtask

    logic [4:0] opl [11] = '{5'h0D, 5'h05, 5'h1B, 5'h19, 5'h00, 5'h04,
                             5'h1C, 5'h08, 5'h18, 5'h0C, 5'h03};

    initial begin
        bit f;
        int idx;
        logic [31:0] inst;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = 32'd0; in_pc = 32'd0;
        @(negedge clk); @(negedge clk);
        chk("reset_valid", vec_t'(out_valid), vec_t'(0));
        chk("reset_ready", vec_t'(in_ready), vec_t'(1));
        chk("reset_data", observed(), vec_t'(0));
        rst = 1'b0;
        @(negedge clk);

        dec_check("addi", 32'hFFF30293, 1, 5, 6, 0, 32'hFFFFFFFF, 1'b0);
        dec_check("sb",   32'h00710223, 2, 0, 2, 7, 32'h00000004, 1'b0);
        dec_check("lb",   32'h01020183, 1, 3, 4, 0, 32'h00000010, 1'b0);
        dec_check("jal",  32'h001000EF, 5, 1, 0, 0, 32'h00000800, 1'b0);
        dec_check("jaln", 32'h800000EF, 5, 1, 0, 0, 32'hFFF00000, 1'b0);
        dec_check("zero", 32'h00000000, 1, 0, 0, 0, 32'h00000000, 1'b1);
        dec_check("ldf3", 32'h00003003, 1, 0, 0, 0, 32'h00000000, 1'b1);
        dec_check("opf7", 32'h40001033, 0, 0, 0, 0, 32'h00000000, 1'b1);

        // Backpressure: four back-to-back items with the consumer stalled.
        drain();
        outlog.delete();
        idx = 0;
        for (int c = 0; c < 14; c++) begin
            in_valid = (idx < 4);
            in_inst = 32'hFFF30293;
            in_pc = 32'(idx * 4);
            out_ready = (c >= 3);
            step(f);
            if (f) idx++;
        end
        chk("bp_count", vec_t'(outlog.size()), vec_t'(4));
        for (int i = 0; i < 4 && i < outlog.size(); i++)
            chk("bp_order", vec_t'(outlog[i]), vec_t'(i * 4));

        // Flush with both entries occupied and a simultaneous input offer.
        drain();
        out_ready = 1'b0; in_valid = 1'b1;
        in_inst = 32'h00710223; in_pc = 32'h200; step(f);
        in_inst = 32'h01020183; in_pc = 32'h204; step(f);
        in_inst = 32'h001000EF; in_pc = 32'h208; flush = 1'b1; step(f);
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", vec_t'(out_valid), vec_t'(0));
        chk("flush_ready", vec_t'(in_ready), vec_t'(1));
        dec_check("post_flush", 32'h00710223, 2, 0, 2, 7, 32'h00000004, 1'b0);

        // Asynchronous reset pulse while both entries hold data.
        out_ready = 1'b0; in_valid = 1'b1;
        in_inst = 32'hFFF30293; in_pc = 32'h300; step(f);
        in_pc = 32'h304; step(f);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_valid", vec_t'(out_valid), vec_t'(0));
        chk("rst_ready", vec_t'(in_ready), vec_t'(1));
        chk("rst_data", observed(), vec_t'(0));
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        step(f);
        dec_check("post_rst", 32'hFFF30293, 1, 5, 6, 0, 32'hFFFFFFFF, 1'b0);

        // Random traffic with random backpressure and occasional flushes.
        for (int c = 0; c < 400; c++) begin
            inst = $urandom;
            idx = $urandom_range(0, 12);
            if (idx < 11) inst[6:2] = opl[idx];
            if ($urandom_range(0, 9) != 0) inst[1:0] = 2'b11;
            if ($urandom_range(0, 1) == 1) inst[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            in_inst = inst;
            in_pc = {$urandom_range(0, 32'h3FFFFFFF), 2'b00};
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 40) == 0);
            step(f);
        end
        flush = 1'b0;
        drain();
        step(f);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
